// File: rtl/mem_pkg.sv
// mem_pkg: shared data-memory definitions.
//   - Region base constants for the ROM/MMIO/RAM decoder (upper address half).
//   - access_mode_t: load/store width codes; bit 2 marks an unsigned load.
//   - mem_req_t: one master's request bundle, used by the arbiter mux.
//   - rr_pick: round-robin winner selection with a burst allowance.
package mem_pkg;

  localparam logic [15:0] ROM_BASE  = 16'h0000;
  localparam logic [15:0] MMIO_BASE = 16'h7000;
  localparam logic [15:0] RAM_BASE  = 16'h8000;

  typedef enum logic [2:0] {
    MODE_BYTE   = 3'd0,
    MODE_HALF   = 3'd1,
    MODE_WORD   = 3'd2,
    MODE_BYTE_U = 3'd4,
    MODE_HALF_U = 3'd5
  } access_mode_t;

  typedef struct packed {
    logic        enable;
    logic [31:0] address;
    logic        write_enable;
    logic [31:0] write_data;
    logic [2:0]  write_mode;
    logic        read_enable;
    logic [2:0]  read_mode;
  } mem_req_t;

  // Returns the winning master index. With both requesting, the last winner
  // keeps the port while it still has burst allowance, otherwise it rotates.
  // With no request the result is don't-care; last is returned.
  function automatic logic rr_pick(input logic [1:0] req, input logic last,
                                   input logic burst_ok);
    case (req)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return burst_ok ? last : ~last;
      default: return last;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between M0 (CPU data
// port) and M1 (boot loader / DMA). Grant is combinational from registered
// arbitration state; the winner's request passes straight to dmem_* in the
// same cycle, and 1-cycle read data is steered back to the issuing master.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   mX_* (X = 0, 1)       master request in; read_data/rvalid/wait out
//   dmem_*                downstream request out; dmem_read_data/dmem_wait in
//
// Registered state:
//   last      | last granted master (0 = M0, 1 = M1)
//   burst_cnt | consecutive accepts by last, saturating at 15
//   locked    | a stalled grant is pinned to last until accepted
//   rsp_valid | read accepted last cycle, data returns now
//   rsp_owner | master that issued that read
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned MAX_BURST   = 4,
  parameter bit          M0_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        m0_enable,
  input  logic [31:0] m0_address,
  input  logic        m0_write_enable,
  input  logic [31:0] m0_write_data,
  input  logic [2:0]  m0_write_mode,
  input  logic        m0_read_enable,
  input  logic [2:0]  m0_read_mode,
  output logic [31:0] m0_read_data,
  output logic        m0_rvalid,
  output logic        m0_wait,

  input  logic        m1_enable,
  input  logic [31:0] m1_address,
  input  logic        m1_write_enable,
  input  logic [31:0] m1_write_data,
  input  logic [2:0]  m1_write_mode,
  input  logic        m1_read_enable,
  input  logic [2:0]  m1_read_mode,
  output logic [31:0] m1_read_data,
  output logic        m1_rvalid,
  output logic        m1_wait,

  output logic        dmem_enable,
  output logic [31:0] dmem_address,
  output logic        dmem_write_enable,
  output logic [31:0] dmem_write_data,
  output logic [2:0]  dmem_write_mode,
  output logic        dmem_read_enable,
  output logic [2:0]  dmem_read_mode,
  input  logic [31:0] dmem_read_data,
  input  logic        dmem_wait
);

  logic       last;
  logic [3:0] burst_cnt;
  logic       locked;
  logic       rsp_valid;
  logic       rsp_owner;

  mem_req_t   req0, req1, gnt_req;
  logic [1:0] req_vec;
  logic       burst_ok;
  logic       winner;
  logic       gnt;
  logic       accept;

  assign req0 = '{enable: m0_enable, address: m0_address,
                  write_enable: m0_write_enable, write_data: m0_write_data,
                  write_mode: m0_write_mode, read_enable: m0_read_enable,
                  read_mode: m0_read_mode};
  assign req1 = '{enable: m1_enable, address: m1_address,
                  write_enable: m1_write_enable, write_data: m1_write_data,
                  write_mode: m1_write_mode, read_enable: m1_read_enable,
                  read_mode: m1_read_mode};

  always_comb begin
    req_vec  = {m1_enable, m0_enable};
    burst_ok = (burst_cnt < 4'(MAX_BURST));
    winner   = locked ? last : rr_pick(req_vec, last, burst_ok);
    // rr_pick only returns a non-requester when nobody requests, so this
    // also covers "no grant" on an idle cycle.
    gnt      = reset_n && req_vec[winner];
    accept   = gnt && !dmem_wait;
    gnt_req  = '0;
    if (gnt) gnt_req = winner ? req1 : req0;

    if (!reset_n)                   m0_wait = m0_enable;
    else if (!m0_enable)            m0_wait = 1'b0;
    else if (gnt && winner == 1'b0) m0_wait = dmem_wait;
    else                            m0_wait = 1'b1;

    if (!reset_n)                   m1_wait = m1_enable;
    else if (!m1_enable)            m1_wait = 1'b0;
    else if (gnt && winner == 1'b1) m1_wait = dmem_wait;
    else                            m1_wait = 1'b1;
  end

  assign dmem_enable       = gnt_req.enable;
  assign dmem_address      = gnt_req.address;
  assign dmem_write_enable = gnt_req.write_enable;
  assign dmem_write_data   = gnt_req.write_data;
  assign dmem_write_mode   = gnt_req.write_mode;
  assign dmem_read_enable  = gnt_req.read_enable;
  assign dmem_read_mode    = gnt_req.read_mode;

  // Response outputs are gated by reset_n directly so a read accepted just
  // before reset never produces a pulse while reset is held.
  assign m0_rvalid    = reset_n && rsp_valid && (rsp_owner == 1'b0);
  assign m1_rvalid    = reset_n && rsp_valid && (rsp_owner == 1'b1);
  assign m0_read_data = m0_rvalid ? dmem_read_data : 32'd0;
  assign m1_read_data = m1_rvalid ? dmem_read_data : 32'd0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last      <= ~M0_PRIORITY;
      burst_cnt <= 4'd0;
      locked    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_owner <= 1'b0;
    end else begin
      rsp_valid <= accept && gnt_req.read_enable;
      if (accept) rsp_owner <= winner;

      if (accept) begin
        last      <= winner;
        locked    <= 1'b0;
        if (winner == last)
          burst_cnt <= (burst_cnt == 4'd15) ? 4'd15 : burst_cnt + 4'd1;
        else
          burst_cnt <= 4'd1;
      end else if (gnt) begin
        // Stalled grant: pin it so contention cannot move it mid-stall.
        locked <= 1'b1;
        last   <= winner;
      end else if (req_vec == 2'b00) begin
        burst_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int unsigned MAXB = 4;
  localparam bit          PRIO = 1'b1;

  logic        clk;
  logic        reset_n;
  logic        en [2];
  logic [31:0] addr [2];
  logic        we [2];
  logic [31:0] wd [2];
  logic [2:0]  wm [2];
  logic        re [2];
  logic [2:0]  rm [2];
  logic [31:0] rd0, rd1;
  logic        rvalid0, rvalid1, wait0, wait1;
  logic        dmem_enable, dmem_write_enable, dmem_read_enable;
  logic [31:0] dmem_address, dmem_write_data;
  logic [2:0]  dmem_write_mode, dmem_read_mode;
  logic [31:0] drd;
  logic        dwait;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.MAX_BURST(MAXB), .M0_PRIORITY(PRIO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_enable(en[0]), .m0_address(addr[0]), .m0_write_enable(we[0]),
    .m0_write_data(wd[0]), .m0_write_mode(wm[0]), .m0_read_enable(re[0]),
    .m0_read_mode(rm[0]), .m0_read_data(rd0), .m0_rvalid(rvalid0), .m0_wait(wait0),
    .m1_enable(en[1]), .m1_address(addr[1]), .m1_write_enable(we[1]),
    .m1_write_data(wd[1]), .m1_write_mode(wm[1]), .m1_read_enable(re[1]),
    .m1_read_mode(rm[1]), .m1_read_data(rd1), .m1_rvalid(rvalid1), .m1_wait(wait1),
    .dmem_enable(dmem_enable), .dmem_address(dmem_address),
    .dmem_write_enable(dmem_write_enable), .dmem_write_data(dmem_write_data),
    .dmem_write_mode(dmem_write_mode), .dmem_read_enable(dmem_read_enable),
    .dmem_read_mode(dmem_read_mode), .dmem_read_data(drd), .dmem_wait(dwait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, how many grants in a row it has had,
  // whether a stalled grant is pinned, and the read waiting to come back.
  int m_last;
  int m_run;
  bit m_locked;
  bit m_pend;
  int m_owner;
  bit acc_flag [2];

  always @(negedge clk) begin
    bit g;
    int w;
    logic [31:0] e_addr, e_wd;
    logic e_en, e_we, e_re;
    logic [2:0] e_wm, e_rm;
    logic e_w0, e_w1;
    w = m_last;
    g = 0;
    acc_flag[0] = 0;
    acc_flag[1] = 0;
    if (!reset_n) begin
      e_w0 = en[0];
      e_w1 = en[1];
    end else begin
      if (m_locked) begin
        w = m_last;
        g = en[w];
      end else if (en[0] && en[1]) begin
        w = (m_run < MAXB) ? m_last : 1 - m_last;
        g = 1;
      end else if (en[0] || en[1]) begin
        w = en[0] ? 0 : 1;
        g = 1;
      end
      e_w0 = en[0] && !(g && w == 0 && !dwait);
      e_w1 = en[1] && !(g && w == 1 && !dwait);
    end
    e_en = g ? en[w] : 1'b0;
    e_addr = g ? addr[w] : 32'd0;
    e_we = g ? we[w] : 1'b0;
    e_wd = g ? wd[w] : 32'd0;
    e_wm = g ? wm[w] : 3'd0;
    e_re = g ? re[w] : 1'b0;
    e_rm = g ? rm[w] : 3'd0;
    chk("dmem_enable", {31'd0, dmem_enable}, {31'd0, e_en});
    chk("dmem_address", dmem_address, e_addr);
    chk("dmem_write_enable", {31'd0, dmem_write_enable}, {31'd0, e_we});
    chk("dmem_write_data", dmem_write_data, e_wd);
    chk("dmem_write_mode", {29'd0, dmem_write_mode}, {29'd0, e_wm});
    chk("dmem_read_enable", {31'd0, dmem_read_enable}, {31'd0, e_re});
    chk("dmem_read_mode", {29'd0, dmem_read_mode}, {29'd0, e_rm});
    chk("m0_wait", {31'd0, wait0}, {31'd0, e_w0});
    chk("m1_wait", {31'd0, wait1}, {31'd0, e_w1});
    chk("m0_rvalid", {31'd0, rvalid0}, {31'd0, reset_n && m_pend && m_owner == 0});
    chk("m1_rvalid", {31'd0, rvalid1}, {31'd0, reset_n && m_pend && m_owner == 1});
    chk("m0_read_data", rd0, (reset_n && m_pend && m_owner == 0) ? drd : 32'd0);
    chk("m1_read_data", rd1, (reset_n && m_pend && m_owner == 1) ? drd : 32'd0);

    // advance the model across the coming clock edge
    if (!reset_n) begin
      m_last = PRIO ? 0 : 1;
      m_run = 0;
      m_locked = 0;
      m_pend = 0;
      m_owner = 0;
    end else if (g && !dwait) begin
      m_run = (w == m_last) ? ((m_run >= 15) ? 15 : m_run + 1) : 1;
      m_last = w;
      m_locked = 0;
      m_pend = re[w];
      m_owner = w;
      acc_flag[w] = 1;
    end else if (g) begin
      m_locked = 1;
      m_last = w;
      m_pend = 0;
    end else begin
      m_pend = 0;
      if (!en[0] && !en[1]) m_run = 0;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic look;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_master(input int x);
    en[x] = 0; addr[x] = 0; we[x] = 0; wd[x] = 0; wm[x] = 0; re[x] = 0; rm[x] = 0;
  endtask

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h8000_2000;

  initial begin
    int exp_g [9];
    exp_g = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    reset_n = 0;
    dwait = 0;
    drd = 0;
    clear_master(0);
    clear_master(1);
    en[0] = 1; addr[0] = 32'h0000_0100; re[0] = 1; rm[0] = 3'd2;

    // reset holds the requester off
    look;
    chk("rst_m0_wait", {31'd0, wait0}, 32'd1);
    chk("rst_dmem_enable", {31'd0, dmem_enable}, 32'd0);
    step;
    reset_n = 1;
    look;
    chk("rel_dmem_enable", {31'd0, dmem_enable}, 32'd1);
    chk("rel_dmem_address", dmem_address, 32'h0000_0100);
    chk("rel_m0_wait", {31'd0, wait0}, 32'd0);
    step;
    en[0] = 0;
    drd = 32'h0BAD_F00D;
    look;
    chk("rel_m0_rvalid", {31'd0, rvalid0}, 32'd1);
    chk("rel_m0_rdata", rd0, 32'h0BAD_F00D);

    // single read from m1
    step;
    en[1] = 1; addr[1] = 32'h8000_0010; re[1] = 1; rm[1] = 3'd2; drd = 0;
    look;
    chk("rd1_dmem_address", dmem_address, 32'h8000_0010);
    chk("rd1_m1_wait", {31'd0, wait1}, 32'd0);
    step;
    en[1] = 0; drd = 32'hDEAD_BEEF;
    look;
    chk("rd1_m1_rvalid", {31'd0, rvalid1}, 32'd1);
    chk("rd1_m1_rdata", rd1, 32'hDEAD_BEEF);
    chk("rd1_m0_rvalid", {31'd0, rvalid0}, 32'd0);

    // contention after a fresh reset: M0 x4, M1 x4, M0
    step;
    reset_n = 0;
    look;
    step;
    reset_n = 1;
    en[0] = 1; addr[0] = A0; we[0] = 1; re[0] = 0; wd[0] = 32'h1111_0000;
    en[1] = 1; addr[1] = A1; we[1] = 1; re[1] = 0; wd[1] = 32'h2222_0000;
    for (int i = 0; i < 9; i++) begin
      look;
      chk("cont_grant_addr", dmem_address, exp_g[i] ? A1 : A0);
      chk("cont_loser_wait", {31'd0, exp_g[i] ? wait0 : wait1}, 32'd1);
      step;
    end

    // stall lock once M0 has used its burst allowance
    reset_n = 0; en[0] = 0; en[1] = 0;
    look;
    step;
    reset_n = 1; en[0] = 1;
    for (int i = 0; i < 4; i++) begin
      look;
      chk("stall_pre_addr", dmem_address, A0);
      step;
    end
    dwait = 1;
    look;
    chk("stall_addr", dmem_address, A0);
    chk("stall_m0_wait", {31'd0, wait0}, 32'd1);
    step;
    en[1] = 1;
    for (int i = 0; i < 2; i++) begin
      look;
      chk("stall_lock_addr", dmem_address, A0);
      chk("stall_m1_wait", {31'd0, wait1}, 32'd1);
      step;
    end
    dwait = 0;
    look;
    chk("stall_accept_addr", dmem_address, A0);
    chk("stall_accept_m0_wait", {31'd0, wait0}, 32'd0);
    step;
    look;
    chk("stall_after_addr", dmem_address, A1);
    chk("stall_after_m0_wait", {31'd0, wait0}, 32'd1);

    // interleaved reads
    step;
    clear_master(0);
    clear_master(1);
    en[0] = 1; re[0] = 1; addr[0] = 32'h7000_0004;
    look;
    chk("il_addr0", dmem_address, 32'h7000_0004);
    step;
    en[0] = 0; re[0] = 0;
    en[1] = 1; re[1] = 1; addr[1] = 32'h0000_0020; drd = 32'h1111_1111;
    look;
    chk("il_m0_rvalid", {31'd0, rvalid0}, 32'd1);
    chk("il_m0_rdata", rd0, 32'h1111_1111);
    chk("il_m1_rvalid_early", {31'd0, rvalid1}, 32'd0);
    step;
    en[1] = 0; re[1] = 0; drd = 32'h2222_2222;
    look;
    chk("il_m1_rvalid", {31'd0, rvalid1}, 32'd1);
    chk("il_m1_rdata", rd1, 32'h2222_2222);
    chk("il_m0_rvalid_late", {31'd0, rvalid0}, 32'd0);

    // reset while a read is in flight
    step;
    en[0] = 1; re[0] = 1; addr[0] = 32'h8000_0040; drd = 0;
    look;
    step;
    reset_n = 0; en[0] = 0; re[0] = 0; drd = 32'h3333_3333;
    look;
    chk("rstrd_m0_rvalid", {31'd0, rvalid0}, 32'd0);
    chk("rstrd_m0_rdata", rd0, 32'd0);
    step;
    reset_n = 1;
    look;
    chk("rstrd_m0_rvalid_after", {31'd0, rvalid0}, 32'd0);
    chk("rstrd_m1_rvalid_after", {31'd0, rvalid1}, 32'd0);

    // randomized traffic; a master that was not accepted holds its request
    for (int n = 0; n < 3000; n++) begin
      bit was_rst;
      was_rst = !reset_n;
      step;
      for (int x = 0; x < 2; x++) begin
        if (!(en[x] && !acc_flag[x] && !was_rst)) begin
          en[x] = ($urandom_range(0, 3) != 0);
          addr[x] = $urandom;
          we[x] = 1'($urandom_range(0, 1));
          re[x] = 1'($urandom_range(0, 1));
          wd[x] = $urandom;
          wm[x] = 3'($urandom_range(0, 7));
          rm[x] = 3'($urandom_range(0, 7));
        end
      end
      dwait = ($urandom_range(0, 3) == 0);
      drd = $urandom;
      reset_n = ($urandom_range(0, 199) != 0);
    end
    step;
    look;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
